// File: rtl/hps_system_leds.sv
// Avalon-MM LED output PIO with atomic set/clear aliases and an optional
// hardware blink engine, enabled by defining HPS_SYSTEM_LEDS_BLINK_EN.
module hps_system_leds #(
  parameter int                WIDTH        = 10,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [31:0]       PERIOD_RESET = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             wr_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;

  assign wr_s = chipselect & ~write_n;
  assign wd_s = writedata[WIDTH-1:0];

  // DATA register next state, including the set/clear aliases
  always_comb begin
    data_d = data_q;
    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_d = wd_s;
        ADDR_OUTSET: data_d = data_q | wd_s;
        ADDR_OUTCLR: data_d = data_q & ~wd_s;
        default:     data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

`ifdef HPS_SYSTEM_LEDS_BLINK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Blink registers and half-period counter; a period write restarts the "on" phase
  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr_s && (address == ADDR_MASK)) begin
      mask_d = wd_s;
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (address == ADDR_PERIOD)) begin
      period_d = writedata;
      cnt_d    = 32'd0;
      phase_d  = 1'b0;
    end else if (period_q == 32'd0) begin
      cnt_d    = 32'd0;
      phase_d  = 1'b0;
    end else if (cnt_q == (period_q - 32'd1)) begin
      cnt_d    = 32'd0;
      phase_d  = ~phase_q;
    end else begin
      cnt_d    = cnt_q + 32'd1;
    end
  end

  // Blink engine state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= {WIDTH{1'b0}};
      period_q <= PERIOD_RESET;
      cnt_q    <= 32'd0;
      phase_q  <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});

  // Read mux; unqualified by chipselect so it tracks address every cycle
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0] = data_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
      ADDR_PERIOD: readdata_d            = period_q;
      default:     readdata_d            = 32'd0;
    endcase
  end
`else
  logic unused_wd_s;
  assign unused_wd_s = ^writedata;

  assign out_port = data_q;

  // Read mux; unqualified by chipselect so it tracks address every cycle
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
      default:   readdata_d            = 32'd0;
    endcase
  end
`endif

  // DATA and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      readdata_q <= 32'd0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_hps_system_leds.sv
// Randomized + directed bench for hps_system_leds against a cycle-count based
// reference model (phase = (edges since epoch / period) mod 2).
module tb_hps_system_leds;

`ifdef HPS_SYSTEM_LEDS_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  hps_system_leds #(
    .WIDTH(10),
    .RESET_VALUE(10'h155),
    .PERIOD_RESET(32'd25000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [9:0]  m_data;
  logic [9:0]  m_mask;
  logic [31:0] m_period;
  int unsigned m_n;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_phase();
    if (m_period == 32'd0) return 1'b0;
    return ((m_n / m_period) % 2) == 1;
  endfunction

  function automatic logic [9:0] m_out();
    return m_data ^ (m_mask & {10{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {22'd0, m_data};
      3'd2:    return {22'd0, m_mask};
      3'd3:    return m_period;
      default: return 32'd0;
    endcase
  endfunction

  // one clock cycle: drive, advance model across the edge, then compare
  task automatic cyc(input bit rst, input bit cs, input bit wn,
                     input logic [2:0] a, input logic [31:0] wd);
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    if (rst) begin
      m_data = 10'h155; m_mask = 10'd0;
      m_period = BLINK ? 32'd25000000 : 32'd0;
      m_n = 0; m_rd = 32'd0;
    end else begin
      m_rd = m_read(a);
      m_n++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[9:0];
          3'd2: if (BLINK) m_mask = wd[9:0];
          3'd3: if (BLINK) begin m_period = wd; m_n = 0; end
          3'd4: m_data = m_data | wd[9:0];
          3'd5: m_data = m_data & ~wd[9:0];
          default: ;
        endcase
      end
    end
    #1;
    chk("out_port", {22'd0, out_port}, {22'd0, m_out()});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    chk("rst_out", {22'd0, out_port}, 32'h155);
    chk("rst_rd", readdata, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 32'd0);
    chk("rst_period", readdata, BLINK ? 32'd25000000 : 32'd0);

    // set / clear
    wr(3'd0, 32'h0F0);
    chk("data_wr", {22'd0, out_port}, 32'h0F0);
    wr(3'd4, 32'h003);
    chk("outset", {22'd0, out_port}, 32'h0F3);
    wr(3'd5, 32'h010);
    chk("outclr", {22'd0, out_port}, 32'h0E3);
    idle(3'd0);
    chk("rd_data", readdata, 32'h0E3);

    // blink: period write edge is sample 0
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h001);
    wr(3'd3, 32'd4);
    chk("blink0", {31'd0, out_port[0]}, 32'd0);
    for (int k = 1; k < 12; k++) begin
      idle(3'd0);
      chk("blink", {31'd0, out_port[0]}, BLINK ? ((k / 4) % 2) : 0);
      chk("blink_hi", {23'd0, out_port[9:1]}, 32'd0);
    end
    // OUTSET on the toggle edge
    wr(3'd4, 32'h200);
    chk("set_toggle", {22'd0, out_port}, BLINK ? 32'h201 : 32'h200);

    // mid-half-period period rewrite
    idle(3'd0);
    idle(3'd0);
    wr(3'd3, 32'd2);
    chk("restart0", {31'd0, out_port[0]}, 32'd0);
    idle(3'd0);
    chk("restart1", {31'd0, out_port[0]}, 32'd0);
    idle(3'd0);
    chk("restart2", {31'd0, out_port[0]}, BLINK ? 32'd1 : 32'd0);

    // period 0 freezes blinking
    wr(3'd3, 32'd0);
    for (int k = 0; k < 100; k++) begin
      idle(3'd1);
      chk("frozen", {22'd0, out_port}, 32'h200);
    end

    // blink registers visibility
    wr(3'd2, 32'h3FF);
    wr(3'd3, 32'd4);
    idle(3'd2);
    chk("rd_mask", readdata, BLINK ? 32'h3FF : 32'd0);
    idle(3'd3);
    chk("rd_period", readdata, BLINK ? 32'd4 : 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd3) wd = 32'($urandom_range(0, 7));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 1) == 0), a, wd);
    end

    // reset during a write discards the write
    wr(3'd3, 32'd3);
    idle(3'd0);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h3FF);
    chk("rst_wr_out", {22'd0, out_port}, 32'h155);
    idle(3'd0);
    chk("rst_wr_rd", readdata, 32'h155);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hps_system_leds.md
# hps_system_leds

Avalon-MM output PIO slave that drives the board LEDs from the HPS lightweight bridge. It is the write-direction counterpart of the key-input PIO on the same interconnect. It holds a software-written data register with atomic set/clear aliases. An optional hardware blink engine toggles a selectable subset of bits at a programmable period, so software does not need to poll a timer.

## Interface
- WIDTH, 10, number of LED outputs (1..32)
- RESET_VALUE, 0, data register value after reset
- PERIOD_RESET, 25000000, blink period register value after reset (clk cycles per half-period)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- address  input  3  word address of register
- chipselect  input  1  slave selected
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data; bits above WIDTH ignored
- readdata  output  32  registered read data; zero-extended above WIDTH
- out_port  output  WIDTH  LED drive

## Operation
- Register map (word addresses):
  - 0 DATA: RW.
  - 1: reserved, reads 0, writes ignored.
  - 2 BLINK_MASK: RW, WIDTH bits.
  - 3 BLINK_PERIOD: RW, 32 bits.
  - 4 OUTSET: WO, DATA |= writedata.
  - 5 OUTCLEAR: WO, DATA &= ~writedata.
  - 6, 7: reserved.
- Write occurs when chipselect=1 and write_n=0, on that clk edge.
- Reads of 4/5/6/7 return 0.
- Read path matches the key PIO: readdata is updated every cycle from the address-selected register, with no chipselect qualification.
- Blink engine:
  - 32-bit counter cnt and 1-bit phase.
  - When BLINK_PERIOD != 0: if cnt == BLINK_PERIOD-1 then cnt <= 0 and phase <= ~phase; otherwise cnt <= cnt+1.
  - When BLINK_PERIOD == 0: cnt <= 0, phase <= 0 (blinking frozen, steady DATA).
- Any write to BLINK_PERIOD clears cnt and phase in the same edge. A period change therefore always starts a fresh "on" half-period.
- Writes to BLINK_MASK do not disturb cnt/phase.
- out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}). This is combinational from registers only, with no bus-input path.
- Reset values:
  - DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=PERIOD_RESET.
  - cnt=0, phase=0, readdata=0.
  - out_port=RESET_VALUE.
- Reset mid-blink returns all state to reset values on that edge. A bus write in the reset cycle is discarded.
- The phase toggle and a DATA/OUTSET/OUTCLEAR write on the same edge both take effect.

## Timing
- Write latency: register updates on the write edge. out_port reflects the change in the following cycle.
- Read latency: 1 cycle. readdata at edge T+1 reflects the address presented at edge T and the register contents before edge T.
- Read-after-write to the same register on back-to-back cycles returns the new value.
- Blink half-period is exactly BLINK_PERIOD clk cycles. The first toggle after a period write or reset comes BLINK_PERIOD cycles after that edge.
- No wait states; never back-pressures.

## Configuration
- HPS_SYSTEM_LEDS_BLINK_EN
  - Defined: blink engine, BLINK_MASK and BLINK_PERIOD registers present as described.
  - Undefined: counter and phase not built; addresses 2 and 3 read 0 and ignore writes; out_port = DATA.
  - Undefined: DATA/OUTSET/OUTCLEAR behaviour and all latencies unchanged.

## Test plan
- Reset:
  - Stimulus: RESET_VALUE=10'h155, assert reset 2 cycles.
  - Response: out_port=10'h155, readdata=0, a read of addr 3 returns 25000000.
- Set/clear:
  - Stimulus: write DATA=0x0F0, then OUTSET=0x003, then OUTCLEAR=0x010.
  - Response: out_port is 0x0F0, 0x0F3, 0x0E3 on the cycles after each write; a read of addr 0 returns 0x0E3 one cycle later.
- Blink:
  - Stimulus: DATA=0, BLINK_MASK=0x001, BLINK_PERIOD=4.
  - Response: out_port[0] is low for 4 cycles after the period write, then high 4, low 4. Bits 9:1 stay 0.
- Period edge cases:
  - Stimulus: with blinking active, write BLINK_PERIOD=0.
  - Response: phase=0 next cycle and out_port=DATA steady for 100 cycles.
  - Stimulus: rewrite BLINK_PERIOD=2 mid-half-period.
  - Response: counting restarts from 0.
- Simultaneous events and reset:
  - Stimulus: OUTSET=0x200 on the same edge as a phase toggle.
  - Response: both bit 9 set and the toggle are applied.
  - Stimulus: assert reset during a write.
  - Response: the write is lost and reset values are present.
- Macro off:
  - Stimulus: build without HPS_SYSTEM_LEDS_BLINK_EN; write addr 2=0x3FF and addr 3=4.
  - Response: reads of addr 2 and addr 3 return 0; out_port tracks DATA only.
